lfsr_step_ctrl: RTL and testbench
=================================

Name: lfsr_step_ctrl

Overview:
- Sequencer for the Fibonacci LFSR datapath in the top design.
- Converts raw seed_pulse/lfsr_pulse levels, or an internal auto-run tick, into single-cycle load/step strobes for the LFSR.
- Checks every LFSR output for lock-up and measures the sequence period.
- Drives the error flag and period/step count consumed by the 7-segment display path.

Parameters:
- WIDTH, 8, LFSR width in bits.
- COUNT, 50000000, clk cycles between auto-run steps (must be >= 1; 1 = simulation).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- seed  in  WIDTH  seed value, sampled when a seed event is accepted
- seed_pulse  in  1  raw level; rising edge = load-seed request
- lfsr_pulse  in  1  raw level; rising edge = single-step request
- auto_en  in  1  1 = step automatically every COUNT cycles
- lfsr_q  in  WIDTH  current LFSR state (registered in LFSR, updates the edge after lfsr_step/lfsr_load)
- lfsr_load  out  1  one-cycle load strobe to LFSR
- lfsr_seed  out  WIDTH  registered seed presented with lfsr_load
- lfsr_step  out  1  one-cycle shift strobe to LFSR
- ready  out  1  high in S_READY
- step_count  out  WIDTH+1  steps since last load/period wrap
- period  out  WIDTH+1  last measured period, 0 until first wrap
- period_done  out  1  one-cycle pulse when LFSR returns to seed
- error  out  1  sticky error flag

Behaviour:
- Reset (reset=0, async): all outputs 0; state S_EMPTY; synchronisers, prescaler and pending flags cleared.
- Input conditioning: seed_pulse and lfsr_pulse each pass a 2-flop synchroniser plus an edge register. A rising edge produces a one-cycle event 3 clk edges after the first edge that samples the input high. A level held high produces exactly one event.
- Events are latched as pending (seed_pend, step_pend) and served only in S_EMPTY/S_READY/S_ERROR, so no event is lost during S_STEP/S_CHECK.
- Auto tick: prescaler counts 0..COUNT-1 while auto_en=1; the tick fires at COUNT-1 and sets step_pend. Prescaler is held at 0 while auto_en=0.
- States:
  - S_EMPTY: no valid seed. A step event is discarded. A seed event with seed!=0 goes to S_LOAD. A seed event with seed==0 sets error and goes to S_ERROR.
  - S_LOAD (1 cycle): lfsr_load=1, lfsr_seed=seed latched at acceptance; step_count<=0; period unchanged; error<=0. Goes to S_READY.
  - S_READY: ready=1. A seed event has priority over a step event; when both are pending, the step is dropped. A step event goes to S_STEP.
  - S_STEP (1 cycle): lfsr_step=1. Goes to S_CHECK.
  - S_CHECK (1 cycle, lfsr_q already updated):
    - If lfsr_q==0: error<=1, go to S_ERROR.
    - Else if lfsr_q==lfsr_seed: period<=step_count+1, period_done=1, step_count<=0.
    - Else: step_count<=step_count+1; if the new value equals 2^WIDTH then error<=1, go to S_ERROR (period exceeds maximal length).
    - Otherwise go to S_READY.
  - S_ERROR: error=1 held; step events discarded. A seed event with seed!=0 goes to S_LOAD, which clears error.
- Step throughput: one step per 3 cycles max. An auto tick arriving while step_pend is already set is merged, not queued.
- Reset mid-operation: immediate return to S_EMPTY, strobes drop in the same instant, and period is cleared.
- step_count saturates logically via the error check; it never wraps silently.

Test Plan:
- Reset, then seed=8'hB8 with a seed_pulse rise -> lfsr_load high exactly 1 cycle, 3 edges after the first sample; lfsr_seed=8'hB8; ready=1 next cycle; error=0.
- seed=0 with a seed_pulse rise -> no lfsr_load; error=1; state S_ERROR. A following lfsr_pulse rise -> no lfsr_step.
- COUNT=1, auto_en=1, maximal-length 8-bit LFSR seeded 8'h01 -> lfsr_step every 3 cycles; period_done after 255 steps; period=255; step_count back to 0.
- Force lfsr_q=0 in the cycle after lfsr_step -> error=1; a later seed_pulse with seed=8'h5A -> S_LOAD, error=0, ready=1.
- seed_pulse and lfsr_pulse rising together in S_READY -> only lfsr_load issued; no lfsr_step; step_count=0.
- reset driven low during S_STEP -> lfsr_step, ready and error drop immediately; after release, state S_EMPTY and a step event is ignored.

Source files
------------

// File: rtl/lfsr_step_ctrl.sv
// Sequencer for a Fibonacci LFSR: turns seed/step pulses or an auto tick into load/step strobes, checks lock-up, measures period.
// Pulse events act 3 edges after first sample; events during a step are held pending, so at most one step per 3 cycles.
module lfsr_step_ctrl #(
  parameter int WIDTH = 8,
  parameter int COUNT = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_pulse,
  input  logic             lfsr_pulse,
  input  logic             auto_en,
  input  logic [WIDTH-1:0] lfsr_q,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_step,
  output logic             ready,
  output logic [WIDTH:0]   step_count,
  output logic [WIDTH:0]   period,
  output logic             period_done,
  output logic             error
);

  localparam int              PW        = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(COUNT - 1);
  localparam logic [WIDTH:0]  SC_LIMIT  = {1'b1, {WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_EMPTY, S_LOAD, S_READY, S_STEP, S_CHECK, S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic             seed_s1_q, seed_s2_q, seed_s3_q;
  logic             step_s1_q, step_s2_q, step_s3_q;
  logic             seed_pend_q, seed_pend_d;
  logic             step_pend_q, step_pend_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] lfsr_seed_q, lfsr_seed_d;
  logic [WIDTH:0]   step_count_q, step_count_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             error_q, error_d;
  logic             period_done_q, period_done_d;
  logic             load_q, step_q, ready_q;
  logic             seed_evt, step_evt, tick, seed_now, step_now;
  logic [WIDTH:0]   sc_inc;

  assign seed_evt = seed_s2_q & ~seed_s3_q;
  assign step_evt = step_s2_q & ~step_s3_q;
  assign tick     = auto_en && (presc_q == PRESC_MAX);
  assign seed_now = seed_pend_q | seed_evt;
  assign step_now = step_pend_q | step_evt | tick;
  assign sc_inc   = step_count_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    seed_pend_d   = seed_now;
    step_pend_d   = step_now;
    presc_d       = (!auto_en || tick) ? '0 : presc_q + 1'b1;
    lfsr_seed_d   = lfsr_seed_q;
    step_count_d  = step_count_q;
    period_d      = period_q;
    error_d       = error_q;
    period_done_d = 1'b0;
    case (state_q)
      S_EMPTY, S_READY, S_ERROR: begin
        // Steps are only honoured in READY; a seed event always wins and drops any pending step.
        step_pend_d = 1'b0;
        if (seed_now) begin
          seed_pend_d = 1'b0;
          if (seed != '0) begin
            state_d      = S_LOAD;
            lfsr_seed_d  = seed;
            step_count_d = '0;
            error_d      = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end else if (step_now && state_q == S_READY) begin
          state_d = S_STEP;
        end
      end
      S_LOAD:  state_d = S_READY;
      S_STEP:  state_d = S_CHECK;
      S_CHECK: begin
        if (lfsr_q == '0) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end else if (lfsr_q == lfsr_seed_q) begin
          period_d      = sc_inc;
          period_done_d = 1'b1;
          step_count_d  = '0;
          state_d       = S_READY;
        end else begin
          step_count_d = sc_inc;
          if (sc_inc == SC_LIMIT) begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end else begin
            state_d = S_READY;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_EMPTY;
      seed_s1_q     <= 1'b0;
      seed_s2_q     <= 1'b0;
      seed_s3_q     <= 1'b0;
      step_s1_q     <= 1'b0;
      step_s2_q     <= 1'b0;
      step_s3_q     <= 1'b0;
      seed_pend_q   <= 1'b0;
      step_pend_q   <= 1'b0;
      presc_q       <= '0;
      lfsr_seed_q   <= '0;
      step_count_q  <= '0;
      period_q      <= '0;
      error_q       <= 1'b0;
      period_done_q <= 1'b0;
      load_q        <= 1'b0;
      step_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      seed_s1_q     <= seed_pulse;
      seed_s2_q     <= seed_s1_q;
      seed_s3_q     <= seed_s2_q;
      step_s1_q     <= lfsr_pulse;
      step_s2_q     <= step_s1_q;
      step_s3_q     <= step_s2_q;
      seed_pend_q   <= seed_pend_d;
      step_pend_q   <= step_pend_d;
      presc_q       <= presc_d;
      lfsr_seed_q   <= lfsr_seed_d;
      step_count_q  <= step_count_d;
      period_q      <= period_d;
      error_q       <= error_d;
      period_done_q <= period_done_d;
      load_q        <= (state_d == S_LOAD);
      step_q        <= (state_d == S_STEP);
      ready_q       <= (state_d == S_READY);
    end
  end

  assign lfsr_load   = load_q;
  assign lfsr_seed   = lfsr_seed_q;
  assign lfsr_step   = step_q;
  assign ready       = ready_q;
  assign step_count  = step_count_q;
  assign period      = period_q;
  assign period_done = period_done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Bench for lfsr_step_ctrl: drives an 8-bit maximal-length LFSR from the strobes and checks
// timing, period measurement, error handling and a randomized transaction-level model.
module tb_lfsr_step_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] seed;
  logic         seed_pulse, lfsr_pulse, auto_en, force_zero;
  logic [W-1:0] env_q, lfsr_q;
  logic         lfsr_load, lfsr_step, ready, period_done, error;
  logic [W-1:0] lfsr_seed;
  logic [W:0]   step_count, period;

  lfsr_step_ctrl #(.WIDTH(W), .COUNT(1)) dut (
    .clk(clk), .reset(reset), .seed(seed), .seed_pulse(seed_pulse),
    .lfsr_pulse(lfsr_pulse), .auto_en(auto_en), .lfsr_q(lfsr_q),
    .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_step(lfsr_step),
    .ready(ready), .step_count(step_count), .period(period),
    .period_done(period_done), .error(error)
  );

  always #5 clk = ~clk;

  // Taps 8,6,5,4: maximal length, every nonzero seed has period 255.
  function automatic logic [W-1:0] nxt(input logic [W-1:0] v);
    return {v[W-2:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset)         env_q <= '0;
    else if (lfsr_load) env_q <= lfsr_seed;
    else if (lfsr_step) env_q <= nxt(env_q);
  end
  assign lfsr_q = force_zero ? '0 : env_q;

  typedef struct {
    logic [W-1:0] seed;
    logic         exp_err;
    logic [W:0]   exp_period;
  } vec_t;
  vec_t vecs [4];

  int n_cmp = 0, n_bad = 0, cyc = 0, steps_seen = 0, loads_seen = 0;
  int l0, s0, nst, last, bad, k, m_sc, m_period;
  bit found, ok, m_valid, m_err;
  logic [W-1:0] sd, m_seed, m_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick_cyc();
    @(negedge clk);
    cyc++;
    if (lfsr_step) steps_seen++;
    if (lfsr_load) loads_seen++;
  endtask

  task automatic pulse_seed(input logic [W-1:0] v);
    seed = v;
    seed_pulse = 1'b1;
    tick_cyc();
    seed_pulse = 1'b0;
  endtask

  task automatic pulse_step();
    lfsr_pulse = 1'b1;
    tick_cyc();
    lfsr_pulse = 1'b0;
  endtask

  task automatic wait_step(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick_cyc();
      if (lfsr_step) got = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h00, 1'b1, 9'd0};
    vecs[1] = '{8'hB8, 1'b0, 9'd255};
    vecs[2] = '{8'h5A, 1'b0, 9'd255};
    vecs[3] = '{8'h01, 1'b0, 9'd255};
    reset = 1'b0; seed = '0; seed_pulse = 1'b0; lfsr_pulse = 1'b0;
    auto_en = 1'b0; force_zero = 1'b0;

    repeat (3) tick_cyc();
    check("rst_strobes", 32'({lfsr_load, lfsr_step, ready, period_done, error}), 32'd0);
    check("rst_counts", 32'({step_count, period}), 32'd0);
    check("rst_seed", 32'(lfsr_seed), 32'd0);
    reset = 1'b1;
    repeat (2) tick_cyc();
    check("empty_not_ready", 32'(ready), 32'd0);

    for (int i = 0; i < 4; i++) begin
      l0 = loads_seen;
      pulse_seed(vecs[i].seed);
      tick_cyc();
      check("load_early", 32'(lfsr_load), 32'd0);
      tick_cyc();
      check("load_strobe", 32'(lfsr_load), 32'(!vecs[i].exp_err));
      if (!vecs[i].exp_err) check("load_seed", 32'(lfsr_seed), 32'(vecs[i].seed));
      tick_cyc();
      check("load_one_cycle", 32'(lfsr_load), 32'd0);
      check("load_count", 32'(loads_seen - l0), 32'(!vecs[i].exp_err));
      check("load_ready", 32'(ready), 32'(!vecs[i].exp_err));
      check("load_error", 32'(error), 32'(vecs[i].exp_err));
      if (vecs[i].exp_err) begin
        s0 = steps_seen;
        pulse_step();
        repeat (8) tick_cyc();
        check("err_step_ignored", 32'(steps_seen - s0), 32'd0);
        check("err_held", 32'(error), 32'd1);
      end else begin
        auto_en = 1'b1;
        nst = 0; bad = 0; last = 0; found = 1'b0;
        for (int c = 0; c < 1200 && !found; c++) begin
          tick_cyc();
          if (lfsr_step) begin
            if (nst > 0 && cyc - last != 3) bad++;
            last = cyc;
            nst++;
          end
          if (period_done) found = 1'b1;
        end
        check("period_found", 32'(found), 32'd1);
        check("period_value", 32'(period), 32'(vecs[i].exp_period));
        check("period_sc_zero", 32'(step_count), 32'd0);
        check("period_steps", 32'(nst), 32'(vecs[i].exp_period));
        check("step_gap_3", 32'(bad), 32'd0);
        auto_en = 1'b0;
        repeat (8) tick_cyc();
      end
    end

    // Lock-up: LFSR reads back zero after a step.
    force_zero = 1'b1;
    pulse_step();
    wait_step(ok);
    check("fz_step_seen", 32'(ok), 32'd1);
    tick_cyc();
    tick_cyc();
    check("fz_error", 32'(error), 32'd1);
    check("fz_not_ready", 32'(ready), 32'd0);
    force_zero = 1'b0;
    pulse_seed(8'h5A);
    tick_cyc();
    tick_cyc();
    check("fz_reload", 32'(lfsr_load), 32'd1);
    check("fz_error_clr", 32'(error), 32'd0);
    tick_cyc();
    check("fz_ready", 32'(ready), 32'd1);

    // Simultaneous seed and step in READY.
    for (int j = 0; j < 3; j++) begin
      pulse_step();
      repeat (5) tick_cyc();
    end
    check("pre_sc", 32'(step_count), 32'd3);
    l0 = loads_seen; s0 = steps_seen;
    seed = 8'hB8; seed_pulse = 1'b1; lfsr_pulse = 1'b1;
    tick_cyc();
    seed_pulse = 1'b0; lfsr_pulse = 1'b0;
    repeat (8) tick_cyc();
    check("both_loads", 32'(loads_seen - l0), 32'd1);
    check("both_no_step", 32'(steps_seen - s0), 32'd0);
    check("both_sc", 32'(step_count), 32'd0);
    check("both_seed", 32'(lfsr_seed), 32'hB8);

    // Reset while in S_STEP.
    pulse_step();
    wait_step(ok);
    check("rs_step_seen", 32'(ok), 32'd1);
    reset = 1'b0;
    #1;
    check("rs_strobes", 32'({lfsr_step, ready, error}), 32'd0);
    check("rs_period", 32'(period), 32'd0);
    repeat (2) tick_cyc();
    reset = 1'b1;
    s0 = steps_seen;
    pulse_step();
    repeat (8) tick_cyc();
    check("rs_step_ignored", 32'(steps_seen - s0), 32'd0);
    check("rs_empty", 32'({ready, step_count}), 32'd0);

    // Randomized loads and manual steps against a transaction-level model.
    m_valid = 1'b0; m_err = 1'b0; m_sc = 0; m_period = 0; m_seed = '0; m_lfsr = '0;
    for (int it = 0; it < 8; it++) begin
      sd = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      pulse_seed(sd);
      repeat (4) tick_cyc();
      if (sd == 8'h00) begin
        m_err = 1'b1; m_valid = 1'b0;
      end else begin
        m_err = 1'b0; m_valid = 1'b1; m_sc = 0; m_seed = sd; m_lfsr = sd;
      end
      s0 = steps_seen;
      k = int'($urandom_range(0, 300));
      for (int j = 0; j < k; j++) begin
        lfsr_pulse = 1'b1;
        repeat ($urandom_range(1, 2)) tick_cyc();
        lfsr_pulse = 1'b0;
        repeat ($urandom_range(3, 5)) tick_cyc();
        if (m_valid) begin
          m_lfsr = nxt(m_lfsr);
          if (m_lfsr == m_seed) begin
            m_period = m_sc + 1;
            m_sc = 0;
          end else begin
            m_sc++;
          end
        end
      end
      repeat (6) tick_cyc();
      check("rnd_sc", 32'(step_count), 32'(m_sc));
      check("rnd_period", 32'(period), 32'(m_period));
      check("rnd_error", 32'(error), 32'(m_err));
      check("rnd_ready", 32'(ready), 32'(m_valid));
      check("rnd_steps", 32'(steps_seen - s0), m_valid ? 32'(k) : 32'd0);
      if (m_valid) check("rnd_lfsr", 32'(lfsr_q), 32'(m_lfsr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
